// File: rtl/if_stage_if.sv
// Instruction-memory request/response bus between the fetch stage and memory.
// The bus allows at most one outstanding request, and memory always accepts it.
interface if_stage_if;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rvalid,
        output imem_rdata
    );
endinterface

// File: rtl/if_stage.sv
// Instruction fetch stage with the IF/ID pipeline register. It honours stall, flush and
// branch redirects, and it inserts a NOP bubble whenever no instruction is delivered.
module if_stage #(
    parameter logic [63:0] RESET_PC  = 64'h0,
    parameter logic [31:0] NOP_INSTR = 32'h00000033
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic        branch_taken,
    input  logic [63:0] branch_target,
    if_stage_if.master  imem,
    output logic [63:0] ifid_pc_out,
    output logic [31:0] ifid_instruction_out,
    output logic        ifid_valid_out,
    output logic        fetch_busy
);

    localparam logic [1:0] S_ISSUE = 2'd0;
    localparam logic [1:0] S_WAIT  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_HOLD  = 2'd3;

    logic [1:0]  state_q, state_d;
    logic [63:0] pc_q, pc_d;
    logic [63:0] hold_pc_q, hold_pc_d;
    logic [31:0] hold_instr_q, hold_instr_d;
    logic [63:0] ifid_pc_q, ifid_pc_d;
    logic [31:0] ifid_instr_q, ifid_instr_d;
    logic        ifid_valid_q, ifid_valid_d;

    logic        deliver;
    logic [63:0] dlv_pc;
    logic [31:0] dlv_instr;

    assign imem.imem_req  = (state_q == S_ISSUE);
    assign imem.imem_addr = pc_q;
    assign fetch_busy     = (state_q != S_ISSUE);

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        hold_pc_d    = hold_pc_q;
        hold_instr_d = hold_instr_q;
        deliver      = 1'b0;
        dlv_pc       = pc_q;
        dlv_instr    = imem.imem_rdata;

        case (state_q)
            S_ISSUE: begin
                // A redirect in the issue cycle leaves a stale request in flight.
                if (branch_taken) begin
                    pc_d    = branch_target;
                    state_d = S_DRAIN;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem.imem_rvalid) begin
                    if (branch_taken) begin
                        pc_d    = branch_target;
                        state_d = S_ISSUE;
                    end else if (flush) begin
                        state_d = S_ISSUE;
                    end else if (stall) begin
                        hold_pc_d    = pc_q;
                        hold_instr_d = imem.imem_rdata;
                        state_d      = S_HOLD;
                    end else begin
                        deliver = 1'b1;
                        pc_d    = pc_q + 64'd4;
                        state_d = S_ISSUE;
                    end
                end else if (branch_taken) begin
                    pc_d    = branch_target;
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (branch_taken) begin
                    pc_d = branch_target;
                end
                if (imem.imem_rvalid) begin
                    state_d = S_ISSUE;
                end
            end
            S_HOLD: begin
                if (branch_taken) begin
                    pc_d         = branch_target;
                    hold_pc_d    = 64'd0;
                    hold_instr_d = 32'd0;
                    state_d      = S_ISSUE;
                end else if (flush) begin
                    hold_pc_d    = 64'd0;
                    hold_instr_d = 32'd0;
                    state_d      = S_ISSUE;
                end else if (!stall) begin
                    deliver   = 1'b1;
                    dlv_pc    = hold_pc_q;
                    dlv_instr = hold_instr_q;
                    pc_d      = pc_q + 64'd4;
                    state_d   = S_ISSUE;
                end
            end
            default: state_d = S_ISSUE;
        endcase
    end

    always_comb begin
        ifid_pc_d    = 64'd0;
        ifid_instr_d = NOP_INSTR;
        ifid_valid_d = 1'b0;
        if (flush) begin
            ifid_pc_d    = 64'd0;
            ifid_instr_d = NOP_INSTR;
            ifid_valid_d = 1'b0;
        end else if (stall) begin
            ifid_pc_d    = ifid_pc_q;
            ifid_instr_d = ifid_instr_q;
            ifid_valid_d = ifid_valid_q;
        end else if (deliver) begin
            ifid_pc_d    = dlv_pc;
            ifid_instr_d = dlv_instr;
            ifid_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_ISSUE;
            pc_q         <= RESET_PC;
            hold_pc_q    <= 64'd0;
            hold_instr_q <= 32'd0;
            ifid_pc_q    <= 64'd0;
            ifid_instr_q <= NOP_INSTR;
            ifid_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            hold_pc_q    <= hold_pc_d;
            hold_instr_q <= hold_instr_d;
            ifid_pc_q    <= ifid_pc_d;
            ifid_instr_q <= ifid_instr_d;
            ifid_valid_q <= ifid_valid_d;
        end
    end

    assign ifid_pc_out          = ifid_pc_q;
    assign ifid_instruction_out = ifid_instr_q;
    assign ifid_valid_out       = ifid_valid_q;

endmodule
